alu_sweep_ctrl: RTL

Sequential initiator that drives the combinational 2-bit ALU (`sel`, `A`, `B` → `Y`). It accepts one operand pair plus an operation mask over a valid/ready handshake, then steps the ALU through every selected operation in ascending order. After a configurable settle time it captures each 4-bit result and emits it downstream as one valid/ready beat tagged with its opcode.

---
 rtl/alu_sweep_ctrl_if.sv | 48 ++++
 rtl/alu_sweep_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_ctrl_if.sv
// alu_sweep_ctrl_if
// Bundles the signals of alu_sweep_ctrl other than clk and rst_n:
//   - the request handshake: in_valid/in_ready, with in_a, in_b and in_mask
//   - the ALU drive: alu_sel, alu_a and alu_b out, alu_y back
//   - the result handshake: out_valid/out_ready, with out_op, out_y and out_last
//   - busy status
//   - out_mismatch, which exists only when ALU_SWEEP_CHECK_EN is defined
// Modports:
//   master - the sweep controller
//   slave  - the environment (request source, ALU and result sink)
interface alu_sweep_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_a;
  logic [1:0] in_b;
  logic [3:0] in_mask;
  logic [1:0] alu_sel;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [3:0] alu_y;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_op;
  logic [3:0] out_y;
  logic       out_last;
  logic       busy;
`ifdef ALU_SWEEP_CHECK_EN
  logic       out_mismatch;
`endif

  modport master (
    input  in_valid, in_a, in_b, in_mask, alu_y, out_ready,
    output in_ready, alu_sel, alu_a, alu_b, out_valid, out_op, out_y,
           out_last, busy
`ifdef ALU_SWEEP_CHECK_EN
    , output out_mismatch
`endif
  );

  modport slave (
    output in_valid, in_a, in_b, in_mask, alu_y, out_ready,
    input  in_ready, alu_sel, alu_a, alu_b, out_valid, out_op, out_y,
           out_last, busy
`ifdef ALU_SWEEP_CHECK_EN
    , input out_mismatch
`endif
  );
endinterface

// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl
// Purpose:
//   Accepts one operand pair plus an operation mask. It then steps a 2-bit
//   combinational ALU through each selected operation, lowest opcode first.
//   Each operation is held on the ALU for SETTLE_CYCLES cycles. The ALU result
//   is then captured and emitted as one valid/ready beat tagged with its opcode.
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rst_n - asynchronous, active-low reset
//   bus   - alu_sweep_ctrl_if.master (request, ALU drive, result beat, busy)
// Parameters:
//   SETTLE_CYCLES - cycles each operation is held on the ALU before sampling
//                   (legal range 1..15)
// Build option:
//   ALU_SWEEP_CHECK_EN - adds an internal reference ALU. When defined,
//                        out_mismatch flags each captured result that differs
//                        from the reference.
//
// state   | meaning
// S_IDLE  | ready for a request; ALU drive outputs hold their last values
// S_DRIVE | operation on the ALU, settle counter running
// S_EMIT  | result beat presented, waiting for out_ready
module alu_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sweep_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rem_q, rem_d;      // selected ops not yet started
  logic [1:0] alu_sel_q, alu_sel_d;
  logic [1:0] alu_a_q, alu_a_d;
  logic [1:0] alu_b_q, alu_b_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] out_op_q, out_op_d;
  logic [3:0] out_y_q, out_y_d;
  logic       out_last_q, out_last_d;

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // m & (m - 1) clears the lowest set bit.
  function automatic logic [3:0] clr_low(input logic [3:0] m);
    return m & (m - 4'd1);
  endfunction

`ifdef ALU_SWEEP_CHECK_EN
  logic mismatch_q, mismatch_d;

  function automatic logic [3:0] ref_y(input logic [1:0] sel,
                                       input logic [1:0] a,
                                       input logic [1:0] b);
    case (sel)
      2'd0:    return {2'b00, ~a};
      2'd1:    return {2'b00, ~(a & b)};
      2'd2:    return {2'b00, 2'(a + b)};
      default: return {2'b00, 2'(a * b)};
    endcase
  endfunction
`endif

  // The counter is checked against 1 so that its transition to 0 marks the
  // capture edge.
  wire settle_done = (cnt_q <= 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid && (bus.in_mask != 4'd0)) state_d = S_DRIVE;
      S_DRIVE: if (settle_done) state_d = S_EMIT;
      S_EMIT:  if (bus.out_ready) state_d = (rem_q != 4'd0) ? S_DRIVE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == S_IDLE);
    bus.busy     = (state_q != S_IDLE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_y_d     = out_y_q;
    out_last_d  = out_last_q;
`ifdef ALU_SWEEP_CHECK_EN
    mismatch_d  = mismatch_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A zero mask is accepted but changes nothing, so the ALU drive
        // outputs keep their previous values.
        if (bus.in_valid && (bus.in_mask != 4'd0)) begin
          alu_sel_d = low_idx(bus.in_mask);
          rem_d     = clr_low(bus.in_mask);
          alu_a_d   = bus.in_a;
          alu_b_d   = bus.in_b;
          cnt_d     = SETTLE;
        end
      end
      S_DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (settle_done) begin
          out_valid_d = 1'b1;
          out_op_d    = alu_sel_q;
          out_y_d     = bus.alu_y;
          out_last_d  = (rem_q == 4'd0);
`ifdef ALU_SWEEP_CHECK_EN
          mismatch_d  = (bus.alu_y != ref_y(alu_sel_q, alu_a_q, alu_b_q));
`endif
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (rem_q != 4'd0) begin
            alu_sel_d = low_idx(rem_q);
            rem_d     = clr_low(rem_q);
            cnt_d     = SETTLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      rem_q       <= 4'd0;
      alu_sel_q   <= 2'd0;
      alu_a_q     <= 2'd0;
      alu_b_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_op_q    <= 2'd0;
      out_y_q     <= 4'd0;
      out_last_q  <= 1'b0;
`ifdef ALU_SWEEP_CHECK_EN
      mismatch_q  <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_y_q     <= out_y_d;
      out_last_q  <= out_last_d;
`ifdef ALU_SWEEP_CHECK_EN
      mismatch_q  <= mismatch_d;
`endif
    end
  end

  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_last  = out_last_q;
`ifdef ALU_SWEEP_CHECK_EN
  assign bus.out_mismatch = mismatch_q;
`endif

endmodule
